// File: rtl/stream_accum_pkg.sv
// Shared definitions for the stream accumulator: mode encodings and
// result field layout.
package stream_accum_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'd0,
    MODE_RUNSUM = 2'd1,
    MODE_BLKSUM = 2'd2,
    MODE_BLKXOR = 2'd3
  } mode_e;

  // Result word: accumulator at [ACC_W-1:0], word count directly above it.
  localparam int unsigned ACC_OFS = 0;
  localparam int unsigned CNT_W   = 16;

  function automatic int unsigned cnt_ofs(input int unsigned acc_w);
    return acc_w;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO holding one result word plus its last flag.
module stream_fifo2 #(
  parameter int unsigned W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push_en;
  logic         pop_en;

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign full    = count[1];
  assign empty   = (count == 2'd0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_en) rd_ptr <= ~rd_ptr;
      case ({push_en, pop_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_accum.sv
// Stream accumulator: echo, running sum, and per-block sum/xor of the low
// ACC_W bits of each input word, results queued through a 2-entry FIFO.
module stream_accum
  import stream_accum_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ACC_W     = 32,
  parameter int BLOCK_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              s1i_valid,
  output logic              s1i_rdy,
  input  logic [DATA_W-1:0] s1i_data,
  input  logic              s1i_last,
  output logic              s1o_valid,
  input  logic              s1o_rdy,
  output logic [DATA_W-1:0] s1o_data,
  output logic              s1o_last,
  output logic              acc_ovf,
  output logic [31:0]       out_cnt
);

  localparam logic [16:0] BLK_LEN17 = 17'(BLOCK_LEN);
  localparam int unsigned CNT_OFS   = cnt_ofs(ACC_W);

  mode_e              mode_q;
  mode_e              cur_mode;
  logic [15:0]        wcnt;
  logic [15:0]        rcnt;
  logic [15:0]        rcnt_nxt;
  logic [15:0]        res_cnt;
  logic [16:0]        wcnt_inc;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   operand;
  logic [ACC_W:0]     sum;
  logic               accept;
  logic               rs_entry;
  logic               close;
  logic               carry;
  logic               push;
  logic               res_last;
  logic [DATA_W-1:0]  res_data;
  logic               fifo_full;
  logic               fifo_empty;

  assign s1i_rdy   = !fifo_full;
  assign s1o_valid = !fifo_empty;

  // Mode is sampled live at a block boundary so the first word of a block
  // already sees the new mode; inside a block the latched mode_q rules.
  always_comb begin
    cur_mode = (wcnt == '0) ? mode_e'(mode) : mode_q;
    accept   = s1i_valid && s1i_rdy;
    operand  = s1i_data[ACC_W-1:0];
    rs_entry = (cur_mode == MODE_RUNSUM) && (mode_q != MODE_RUNSUM);
    acc_base = rs_entry ? '0 : acc;
    sum      = {1'b0, acc_base} + {1'b0, operand};
    wcnt_inc = {1'b0, wcnt} + 17'd1;
    rcnt_nxt = (rs_entry ? 16'd0 : rcnt) + 16'd1;
    close    = (wcnt_inc == BLK_LEN17) || s1i_last;

    acc_nxt  = acc;
    carry    = 1'b0;
    push     = 1'b0;
    res_last = s1i_last;
    res_cnt  = wcnt_inc[15:0];
    case (cur_mode)
      MODE_ECHO: push = accept;
      MODE_RUNSUM: begin
        acc_nxt = sum[ACC_W-1:0];
        carry   = sum[ACC_W];
        push    = accept;
        res_cnt = rcnt_nxt;
      end
      MODE_BLKSUM: begin
        if (wcnt == '0) begin
          acc_nxt = operand;
        end else begin
          acc_nxt = sum[ACC_W-1:0];
          carry   = sum[ACC_W];
        end
        push     = accept && close;
        res_last = 1'b1;
      end
      default: begin
        acc_nxt  = (wcnt == '0) ? operand : (acc ^ operand);
        push     = accept && close;
        res_last = 1'b1;
      end
    endcase

    res_data = '0;
    if (cur_mode == MODE_ECHO) begin
      res_data = s1i_data;
    end else begin
      res_data[ACC_OFS +: ACC_W] = acc_nxt;
      res_data[CNT_OFS +: CNT_W] = res_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_ECHO;
      wcnt    <= '0;
      rcnt    <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
      out_cnt <= '0;
    end else begin
      if (wcnt == '0) mode_q <= mode_e'(mode);
      if (rs_entry) begin
        acc  <= '0;
        rcnt <= '0;
      end
      if (accept) begin
        if (cur_mode != MODE_ECHO) acc <= acc_nxt;
        if (cur_mode == MODE_RUNSUM) rcnt <= rcnt_nxt;
        if (cur_mode == MODE_BLKSUM || cur_mode == MODE_BLKXOR)
          wcnt <= close ? 16'd0 : wcnt_inc[15:0];
        if (carry) acc_ovf <= 1'b1;
      end
      if (s1o_valid && s1o_rdy) out_cnt <= out_cnt + 32'd1;
    end
  end

  stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({res_last, res_data}),
    .pop       (s1o_rdy),
    .rd_data   ({s1o_last, s1o_data}),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
